// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Holds the last result on bcd/overflow between conversions; start/done handshake.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4,
  parameter int BLANK_LZ  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int          BW      = 4 * DIGITS;
  localparam int          CW      = $clog2(BIN_WIDTH);
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BW-1:0]        scr_q;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_pend_q;

  logic [BW-1:0]        adj;
  logic [BW-1:0]        scr_d;
  logic [BW-1:0]        res_d;
  logic [BIN_WIDTH-1:0] bin_d;
  logic                 lead;

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    // Bits leaving the top digit are dropped; overflow substitution hides the loss.
    scr_d = {adj[BW-2:0], bin_q[BIN_WIDTH-1]};
    bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};

    res_d = scr_d;
    lead  = 1'b1;
    if (ovf_pend_q) begin
      res_d = '1;
    end else if (BLANK_LZ != 0) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (scr_d[4*i +: 4] == 4'd0)) begin
          res_d[4*i +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q      <= bin;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (32'(bin) > MAX_VAL);
            busy       <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= scr_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(BIN_WIDTH - 1)) begin
            bcd      <= res_d;
            overflow <= ovf_pend_q;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default instance plus a BLANK_LZ=1 instance.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start, start_b;
  logic [13:0] bin, bin_b;
  logic        busy, busy_b;
  logic        done, done_b;
  logic [15:0] bcd, bcd_b;
  logic        overflow, overflow_b;

  int errors = 0;
  int checks = 0;
  logic [16:0] sb_q[$];
  logic [16:0] sb_b[$];
  logic [15:0] last_bcd;
  logic        last_ovf;

  bin_to_bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(14), .DIGITS(4), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {overflow, bcd} using decimal arithmetic.
  function automatic logic [16:0] exp_of(input int v, input bit blank);
    logic [15:0] r;
    int          div;
    bit          lead;
    if (v > 9999) return {1'b1, 16'hFFFF};
    div = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    if (blank) begin
      lead = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return {1'b0, r};
  endfunction

  task automatic start_conv(input int v, input bit push);
    bin   = 14'(v);
    start = 1'b1;
    if (push) sb_q.push_back(exp_of(v, 1'b0));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_busy v=%0d: busy=%b want 1", v, busy);
    end
  endtask

  task automatic wait_done(input string name, input int exp_lat, input bit drop_start);
    int          n = 0;
    int          busy_cnt = 0;
    bit          seen = 1'b0;
    bit          hold_bad = 1'b0;
    logic [16:0] e;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (bcd !== last_bcd || overflow !== last_ovf) hold_bad = 1'b1;
      end
    end
    if (drop_start) start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, n);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL %s_hold: bcd/overflow changed before done, want %h/%b", name, last_bcd, last_ovf);
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles, want %0d", name, n, exp_lat);
    end
    checks++;
    if (busy_cnt != exp_lat - 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: busy cycles=%0d busy_at_done=%b, want %0d and 0", name, busy_cnt, busy, exp_lat - 1);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: done with empty queue, bcd=%h", name, bcd);
      return;
    end
    e = sb_q.pop_front();
    if (bcd !== e[15:0] || overflow !== e[16]) begin
      errors++;
      $display("FAIL %s_result: bcd=%h ovf=%b, want bcd=%h ovf=%b", name, bcd, overflow, e[15:0], e[16]);
    end
    last_bcd = e[15:0];
    last_ovf = e[16];
  endtask

  task automatic check_done_low(input string name);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done=%b one cycle after completion, want 0", name, done);
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s_quiet: unexpected done/busy activity, want none", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; bin = 14'd5;
    start_b = 1'b0; bin_b = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b bcd=%h ovf=%b, want 0 0 0000 0", busy, done, bcd, overflow);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_priority: busy=%b, want 0", busy);
    end
    last_bcd = 16'h0000;
    last_ovf = 1'b0;
  endtask

  task automatic test_zero();
    start_conv(0, 1'b1);
    wait_done("zero", 14, 1'b0);
    check_done_low("zero");
  endtask

  task automatic test_values();
    start_conv(1234, 1'b1);
    wait_done("v1234", 14, 1'b0);
    check_done_low("v1234");
    start_conv(9999, 1'b1);
    wait_done("v9999", 14, 1'b0);
    check_done_low("v9999");
  endtask

  task automatic test_overflow();
    start_conv(10000, 1'b1);
    wait_done("ovf10000", 14, 1'b0);
    start_conv(16383, 1'b1);
    wait_done("ovf16383", 14, 1'b0);
    start_conv(5, 1'b1);
    wait_done("after_ovf", 14, 1'b0);
    check_done_low("after_ovf");
  endtask

  task automatic test_mid_start();
    start_conv(42, 1'b1);
    repeat (3) @(negedge clk);
    bin   = 14'd77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mid_start", 10, 1'b0);
    check_quiet("mid_start", 20);
  endtask

  task automatic test_back_to_back();
    bin   = 14'd42;
    start = 1'b1;
    sb_q.push_back(exp_of(42, 1'b0));
    sb_q.push_back(exp_of(42, 1'b0));
    @(negedge clk);
    wait_done("b2b_first", 14, 1'b0);
    wait_done("b2b_second", 15, 1'b1);
    check_done_low("b2b_second");
  endtask

  task automatic test_reset_mid();
    start_conv(1234, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h ovf=%b, want 0 0 0000 0", busy, done, bcd, overflow);
    end
    rst = 1'b0;
    last_bcd = 16'h0000;
    last_ovf = 1'b0;
    check_quiet("reset_mid", 20);
    start_conv(1234, 1'b1);
    wait_done("after_reset_mid", 14, 1'b0);
    check_done_low("after_reset_mid");
  endtask

  task automatic test_blank();
    int          vals[4] = '{42, 0, 1005, 10000};
    logic [16:0] e;
    int          n;
    foreach (vals[k]) begin
      bin_b   = 14'(vals[k]);
      start_b = 1'b1;
      sb_b.push_back(exp_of(vals[k], 1'b1));
      @(negedge clk);
      start_b = 1'b0;
      n = 0;
      while (done_b !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      e = sb_b.pop_front();
      if (done_b !== 1'b1) begin
        errors++;
        $display("FAIL blank_timeout v=%0d: no done within %0d cycles", vals[k], n);
      end else if (n != 14 || bcd_b !== e[15:0] || overflow_b !== e[16]) begin
        errors++;
        $display("FAIL blank_result v=%0d: lat=%0d bcd=%h ovf=%b, want lat=14 bcd=%h ovf=%b",
                 vals[k], n, bcd_b, overflow_b, e[15:0], e[16]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0; start_b = 1'b0; bin_b = '0;
    test_reset();
    test_zero();
    test_values();
    test_overflow();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    test_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
